cwt_butterfly_r2: RTL and testbench

//  Pipelined radix-2 complex butterfly for the CWT/FFT datapath, Q(DW-FRAC).FRAC signed fixed point.

---
 rtl/cwt_butterfly_r2.sv | 173 +++++++++++++++++
 tb/tb_cwt_butterfly_r2.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cwt_butterfly_r2.sv
// cwt_butterfly_r2: four-stage pipelined radix-2 complex butterfly.
// Computes X = A + W*B and Y = A - W*B in signed Q(DW-FRAC).FRAC.
// The twiddle comes from two 1-cycle registered ROMs that share tw_addr.
// One global enable stalls the whole pipeline. A beat handshaken in
// cycle T is presented on out_valid in cycle T+4.
module cwt_butterfly_r2 #(
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int AW    = 5,
  parameter int SCALE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a_re,
  input  logic [DW-1:0] a_im,
  input  logic [DW-1:0] b_re,
  input  logic [DW-1:0] b_im,
  input  logic [AW-1:0] tw_idx,
  output logic [AW-1:0] tw_addr,
  input  logic [DW-1:0] tw_re,
  input  logic [DW-1:0] tw_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] x_re,
  output logic [DW-1:0] x_im,
  output logic [DW-1:0] y_re,
  output logic [DW-1:0] y_im
);

  localparam int PW = 2*DW + 1;
  localparam logic signed [PW-1:0] HALF = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

  logic          en;
  logic          p1_valid, p2_valid, p3_valid, p4_valid;
  logic [DW-1:0] p1_a_re, p1_a_im, p1_b_re, p1_b_im;
  logic [DW-1:0] p2_a_re, p2_a_im, p2_b_re, p2_b_im;
  logic [AW-1:0] p1_idx, p2_idx;
  logic [DW-1:0] p3_a_re, p3_a_im, p3_wb_re, p3_wb_im;

  logic signed [2*DW-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [PW-1:0]   prod_re, prod_im;
  logic [PW-1:0]          sh_re, sh_im;
  logic [DW-1:0]          wb_re, wb_im;
  logic [DW:0]            s_xr, s_xi, s_yr, s_yi;
  logic [DW-1:0]          r_xr, r_xi, r_yr, r_yi;

  function automatic logic [2*DW-1:0] sx2(input logic [DW-1:0] v);
    return {{DW{v[DW-1]}}, v};
  endfunction

  function automatic logic [PW-1:0] sx2p(input logic [2*DW-1:0] v);
    return {v[2*DW-1], v};
  endfunction

  // Clamp a PW-bit value to DW bits: in range when all bits above the DW sign bit agree with it.
  function automatic logic [DW-1:0] sat_p(input logic [PW-1:0] v);
    logic [DW-1:0] r;
    if ((&v[PW-1:DW-1]) || !(|v[PW-1:DW-1])) r = v[DW-1:0];
    else                                      r = v[PW-1] ? MINV : MAXV;
    return r;
  endfunction

  // (s+1)>>>1 equals s[DW:1] + s[0] and always fits DW bits, so scaling never saturates.
  function automatic logic [DW-1:0] finish_s(input logic [DW:0] s);
    logic [DW-1:0] r;
    if (SCALE != 0)            r = s[DW:1] + {{(DW-1){1'b0}}, s[0]};
    else if (s[DW] == s[DW-1]) r = s[DW-1:0];
    else                       r = s[DW] ? MINV : MAXV;
    return r;
  endfunction

  assign en        = !p4_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = p4_valid;
  // While stalled, keep re-reading P2's twiddle so ROM data stays aligned with P2.
  assign tw_addr   = en ? p1_idx : p2_idx;

  // Complex multiply W*B at full precision, then round-half-up and clamp to DW.
  always_comb begin
    m_rr    = $signed(sx2(p2_b_re)) * $signed(sx2(tw_re));
    m_ii    = $signed(sx2(p2_b_im)) * $signed(sx2(tw_im));
    m_ri    = $signed(sx2(p2_b_re)) * $signed(sx2(tw_im));
    m_ir    = $signed(sx2(p2_b_im)) * $signed(sx2(tw_re));
    prod_re = $signed(sx2p(m_rr)) - $signed(sx2p(m_ii));
    prod_im = $signed(sx2p(m_ri)) + $signed(sx2p(m_ir));
    sh_re   = (prod_re + HALF) >>> FRAC;
    sh_im   = (prod_im + HALF) >>> FRAC;
    wb_re   = sat_p(sh_re);
    wb_im   = sat_p(sh_im);
  end

  // Butterfly add/subtract in DW+1 bits, then scale or saturate.
  always_comb begin
    s_xr = {p3_a_re[DW-1], p3_a_re} + {p3_wb_re[DW-1], p3_wb_re};
    s_xi = {p3_a_im[DW-1], p3_a_im} + {p3_wb_im[DW-1], p3_wb_im};
    s_yr = {p3_a_re[DW-1], p3_a_re} - {p3_wb_re[DW-1], p3_wb_re};
    s_yi = {p3_a_im[DW-1], p3_a_im} - {p3_wb_im[DW-1], p3_wb_im};
    r_xr = finish_s(s_xr);
    r_xi = finish_s(s_xi);
    r_yr = finish_s(s_yr);
    r_yi = finish_s(s_yi);
  end

  // P1 captures the input beat, P2 takes it one cycle later as the ROM read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_a_re  <= '0;
      p1_a_im  <= '0;
      p1_b_re  <= '0;
      p1_b_im  <= '0;
      p1_idx   <= '0;
      p2_valid <= 1'b0;
      p2_a_re  <= '0;
      p2_a_im  <= '0;
      p2_b_re  <= '0;
      p2_b_im  <= '0;
      p2_idx   <= '0;
    end else if (en) begin
      p1_valid <= in_valid;
      p1_a_re  <= a_re;
      p1_a_im  <= a_im;
      p1_b_re  <= b_re;
      p1_b_im  <= b_im;
      p1_idx   <= tw_idx;
      p2_valid <= p1_valid;
      p2_a_re  <= p1_a_re;
      p2_a_im  <= p1_a_im;
      p2_b_re  <= p1_b_re;
      p2_b_im  <= p1_b_im;
      p2_idx   <= p1_idx;
    end
  end

  // P3 registers the rounded product with A delayed alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p3_valid <= 1'b0;
      p3_a_re  <= '0;
      p3_a_im  <= '0;
      p3_wb_re <= '0;
      p3_wb_im <= '0;
    end else if (en) begin
      p3_valid <= p2_valid;
      p3_a_re  <= p2_a_re;
      p3_a_im  <= p2_a_im;
      p3_wb_re <= wb_re;
      p3_wb_im <= wb_im;
    end
  end

  // P4 is the output register; it holds while downstream is not ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p4_valid <= 1'b0;
      x_re     <= '0;
      x_im     <= '0;
      y_re     <= '0;
      y_im     <= '0;
    end else if (en) begin
      p4_valid <= p3_valid;
      x_re     <= r_xr;
      x_im     <= r_xi;
      y_re     <= r_yr;
      y_im     <= r_yi;
    end
  end

endmodule

// File: tb/tb_cwt_butterfly_r2.sv
// tb_cwt_butterfly_r2: drives an unscaled and a scaled butterfly with the same
// stimulus and checks both against an integer reference model.
module tb_cwt_butterfly_r2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, out_ready;
  logic [15:0] a_re, a_im, b_re, b_im;
  logic [4:0]  tw_idx;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [4:0]  tw_addr0, tw_addr1;
  logic [15:0] tw_re0, tw_im0, tw_re1, tw_im1;
  logic [15:0] x_re0, x_im0, y_re0, y_im0, x_re1, x_im1, y_re1, y_im1;

  logic [15:0] rom_re [32];
  logic [15:0] rom_im [32];

  typedef struct packed {
    logic [63:0] e0;
    logic [63:0] e1;
    logic [31:0] a;
    logic        pass;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [4:0] acc [16];

  always #5 clk = ~clk;

  cwt_butterfly_r2 #(.DW(16), .FRAC(8), .AW(5), .SCALE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .tw_idx(tw_idx),
    .tw_addr(tw_addr0), .tw_re(tw_re0), .tw_im(tw_im0),
    .out_valid(out_valid0), .out_ready(out_ready),
    .x_re(x_re0), .x_im(x_im0), .y_re(y_re0), .y_im(y_im0)
  );

  cwt_butterfly_r2 #(.DW(16), .FRAC(8), .AW(5), .SCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .tw_idx(tw_idx),
    .tw_addr(tw_addr1), .tw_re(tw_re1), .tw_im(tw_im1),
    .out_valid(out_valid1), .out_ready(out_ready),
    .x_re(x_re1), .x_im(x_im1), .y_re(y_re1), .y_im(y_im1)
  );

  // Twiddle ROMs: 1-cycle registered reads, one pair per DUT.
  always @(posedge clk) begin
    tw_re0 <= rom_re[tw_addr0];
    tw_im0 <= rom_im[tw_addr0];
    tw_re1 <= rom_re[tw_addr1];
    tw_im1 <= rom_im[tw_addr1];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [15:0] fin(input longint v, input bit sc);
    longint r;
    r = sc ? ((v + 1) >>> 1) : sat16(v);
    return 16'(r);
  endfunction

  function automatic logic [63:0] model(input logic [15:0] ar, input logic [15:0] ai,
                                        input logic [15:0] br, input logic [15:0] bi,
                                        input logic [15:0] wr, input logic [15:0] wi,
                                        input bit sc);
    longint a_r, a_i, b_r, b_i, w_r, w_i, wb_r, wb_i;
    a_r  = longint'($signed(ar));
    a_i  = longint'($signed(ai));
    b_r  = longint'($signed(br));
    b_i  = longint'($signed(bi));
    w_r  = longint'($signed(wr));
    w_i  = longint'($signed(wi));
    wb_r = sat16((b_r * w_r - b_i * w_i + 128) >>> 8);
    wb_i = sat16((b_r * w_i + b_i * w_r + 128) >>> 8);
    return {fin(a_r + wb_r, sc), fin(a_i + wb_i, sc), fin(a_r - wb_r, sc), fin(a_i - wb_i, sc)};
  endfunction

  // Scoreboard: record each handshaken beat, check each consumed result.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid0 && out_ready) begin
        chk("beat_pending", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          chk("xy_scale0", {x_re0, x_im0, y_re0, y_im0}, mon_e.e0);
          chk("valid_scale1", 64'(out_valid1), 64'd1);
          chk("xy_scale1", {x_re1, x_im1, y_re1, y_im1}, mon_e.e1);
          if (mon_e.pass)
            chk("w0_passthru", {x_re0, x_im0, y_re0, y_im0}, {mon_e.a, mon_e.a});
        end
      end
      if (in_valid && in_ready0) begin
        mon_e.e0   = model(a_re, a_im, b_re, b_im, rom_re[tw_idx], rom_im[tw_idx], 1'b0);
        mon_e.e1   = model(a_re, a_im, b_re, b_im, rom_re[tw_idx], rom_im[tw_idx], 1'b1);
        mon_e.a    = {a_re, a_im};
        mon_e.pass = (tw_idx >= 5'd28);
        q.push_back(mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic rand_beat();
    a_re   = 16'($urandom);
    a_im   = 16'($urandom);
    b_re   = 16'($urandom);
    b_im   = 16'($urandom);
    tw_idx = 5'($urandom_range(31, 0));
  endtask

  task automatic send_one(input string name, input logic [15:0] ar, input logic [15:0] ai,
                          input logic [15:0] br, input logic [15:0] bi, input logic [4:0] idx,
                          input logic [63:0] exp0, input logic [63:0] exp1);
    int lat;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_re = ar; a_im = ai; b_re = br; b_im = bi; tw_idx = idx;
    @(posedge clk);
    lat = 1;
    #1 in_valid = 1'b0;
    while (!out_valid0 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'd4);
    chk({name, "_s0"}, {x_re0, x_im0, y_re0, y_im0}, exp0);
    chk({name, "_s1"}, {x_re1, x_im1, y_re1, y_im1}, exp1);
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((q.size() != 0 || out_valid0) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int n, cyc, any;
    bit need;
    in_valid = 1'b0; out_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; tw_idx = '0;
    rom_re[0] = 16'h0100; rom_im[0] = 16'h0000;
    rom_re[1] = 16'h00B5; rom_im[1] = 16'hFF4B;
    for (int i = 2; i < 28; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        rom_re[i] = 16'($urandom);
        rom_im[i] = 16'($urandom);
      end else begin
        rom_re[i] = 16'($urandom_range(511, 0)) - 16'd256;
        rom_im[i] = 16'($urandom_range(511, 0)) - 16'd256;
      end
    end
    for (int i = 28; i < 32; i++) begin
      rom_re[i] = '0;
      rom_im[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid0), 64'd0);
    chk("rst_outputs", {x_re0, x_im0, y_re0, y_im0}, 64'd0);
    chk("rst_tw_addr", 64'(tw_addr0), 64'd0);
    chk("rst_in_ready", 64'(in_ready0), 64'd1);
    #2 rst_n = 1'b1;

    // Directed beats with hand-computed results
    send_one("identity", 16'h0100, 16'h0000, 16'h0080, 16'h0000, 5'd0,
             64'h0180_0000_0080_0000, 64'h00C0_0000_0040_0000);
    send_one("complex", 16'h0000, 16'h0000, 16'h0100, 16'h0000, 5'd1,
             64'h00B5_FF4B_FF4B_00B5, 64'h005B_FFA6_FFA6_005B);
    send_one("sat_pos", 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 5'd0,
             64'h7FFF_0000_0000_0000, 64'h7FFF_0000_0000_0000);
    send_one("sat_neg", 16'h8000, 16'h0000, 16'h8000, 16'h0000, 5'd0,
             64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    send_one("w_zero", 16'h1234, 16'hF000, 16'h4000, 16'h4000, 5'd30,
             64'h1234_F000_1234_F000, 64'h091A_F800_091A_F800);
    drain();

    // Back-to-back beats with a 5-cycle downstream stall
    n = 0; cyc = 0; need = 1'b1;
    while (n < 16 && cyc < 80) begin
      @(posedge clk); #1;
      if (need) rand_beat();
      need = 1'b0;
      out_ready = !(cyc >= 8 && cyc < 13);
      in_valid  = 1'b1;
      #1;
      if (!out_ready && n >= 2) begin
        chk("bp_in_ready", 64'(in_ready0), 64'd0);
        chk("bp_tw_addr", 64'(tw_addr0), 64'(acc[n-2]));
      end
      if (in_ready0) begin
        acc[n] = tw_idx;
        n++;
        need = 1'b1;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_all_sent", 64'(n), 64'd16);
    drain();

    // Streaming: 32 beats over every twiddle index
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          @(posedge clk); #1;
          rand_beat();
          tw_idx    = 5'(i);
          out_ready = 1'b1;
          in_valid  = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin
        int w, run;
        w = 0; run = 0;
        while (!out_valid0 && w < 20) begin
          @(posedge clk); #1;
          w++;
        end
        while (out_valid0 && run < 40) begin
          run++;
          @(posedge clk); #1;
        end
        chk("stream_run", 64'(run), 64'd32);
      end
    join
    drain();

    // Random valid/ready traffic
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      rand_beat();
      in_valid  = ($urandom_range(99, 0) < 70);
      out_ready = ($urandom_range(99, 0) < 70);
    end
    @(posedge clk); #1;
    drain();

    // Reset with beats in flight
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rand_beat();
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_reset_valid", 64'(out_valid0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {62'd0, out_valid0, out_valid1}, 64'd0);
    chk("rst_async_outputs", {x_re0, x_im0, y_re0, y_im0}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    any = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid0 || out_valid1) any = 1;
    end
    chk("no_stale_beat", 64'(any), 64'd0);
    send_one("post_reset", 16'h0100, 16'h0000, 16'h0080, 16'h0000, 5'd0,
             64'h0180_0000_0080_0000, 64'h00C0_0000_0040_0000);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
